// File: rtl/measure_pkg.sv
// measure_pkg: shared types and defaults for the measure unit
package measure_pkg;
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_WAIT   = 5'b00010,
    ST_DELAY  = 5'b00100,
    ST_SAMPLE = 5'b01000,
    ST_DONE   = 5'b10000
  } stb_sampler_state;
  localparam int DEF_TIMEOUT_CYCLES = 2**20;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage flip-flop synchronizer for asynchronous inputs
module sync_ff #(
  parameter int WIDTH = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] s_q [STAGES];
  always_ff @(posedge clk_i) begin
    if (rst_i) s_q <= '{default: '0};
    else begin
      s_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) s_q[i] <= s_q[i-1];
    end
  end
  assign q_o = s_q[STAGES-1];
endmodule

// File: rtl/stb_sampler.sv
// stb_sampler: counts comparator hits a programmable delay after each strobe edge
module stb_sampler
  import measure_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int DLY_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stb_i,
  input  logic                 stb_rdy_i,
  input  logic                 comp_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] n_samples_i,
  input  logic [DLY_WIDTH-1:0] delay_i,
  output logic                 busy_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CNT_WIDTH-1:0] hits_o,
  output logic [CNT_WIDTH-1:0] total_o,
  output logic                 err_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  stb_sampler_state state_q, state_d;
  logic [CNT_WIDTH-1:0] n_q, n_d, hits_q, hits_d, total_q, total_d;
  logic [DLY_WIDTH-1:0] dly_q, dly_d, dcnt_q, dcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic err_q, err_d, stb_q, comp_s, stb_edge;
  sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (comp_i),
    .q_o  (comp_s)
  );
  assign stb_edge = stb_i & ~stb_q;
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    dly_d   = dly_q;
    dcnt_d  = dcnt_q;
    tmo_d   = tmo_q;
    hits_d  = hits_q;
    total_d = total_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (start_i) begin
        n_d     = n_samples_i;
        dly_d   = delay_i;
        hits_d  = '0;
        total_d = '0;
        tmo_d   = '0;
        err_d   = 1'b0;
        state_d = (n_samples_i == '0) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: if (stb_edge && stb_rdy_i) begin
        dcnt_d  = dly_q;
        state_d = ST_DELAY;
      end else begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      // edges arriving here are deliberately dropped; long delays skip strobes
      ST_DELAY: if (dcnt_q == '0) state_d = ST_SAMPLE;
                else dcnt_d = dcnt_q - DLY_WIDTH'(1);
      ST_SAMPLE: begin
        total_d = total_q + CNT_WIDTH'(1);
        hits_d  = hits_q + CNT_WIDTH'(comp_s);
        tmo_d   = '0;
        state_d = (total_d == n_q) ? ST_DONE : ST_WAIT;
      end
      ST_DONE: state_d = ready_i ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      dly_q   <= '0;
      dcnt_q  <= '0;
      tmo_q   <= '0;
      hits_q  <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      dly_q   <= dly_d;
      dcnt_q  <= dcnt_d;
      tmo_q   <= tmo_d;
      hits_q  <= hits_d;
      total_q <= total_d;
      err_q   <= err_d;
      stb_q   <= stb_i;
    end
  end
  assign busy_o  = state_q != ST_IDLE;
  assign valid_o = state_q == ST_DONE;
  assign hits_o  = hits_q;
  assign total_o = total_q;
  assign err_o   = err_q;
endmodule

// File: tb/tb_stb_sampler.sv
// tb_stb_sampler: directed vector table plus hand sequences for stb_sampler
module tb_stb_sampler;
  logic clk = 1'b0, rst = 1'b1;
  logic stb_i, stb_rdy_i, comp_i, start_i = 1'b0, ready_i = 1'b0;
  logic [15:0] n_samples_i = '0;
  logic [31:0] delay_i = '0;
  logic busy_o, valid_o, err_o;
  logic [15:0] hits_o, total_o;
  int n_vec = 0, n_err = 0;
  int p = 0, stb_count = 0, rdy_until = 0, comp_mode = 0;
  logic stb_en = 1'b1, cur_masked = 1'b0;

  stb_sampler #(.CNT_WIDTH(16), .DLY_WIDTH(32), .TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk), .rst_i(rst), .stb_i(stb_i), .stb_rdy_i(stb_rdy_i), .comp_i(comp_i),
    .start_i(start_i), .n_samples_i(n_samples_i), .delay_i(delay_i), .busy_o(busy_o),
    .valid_o(valid_o), .ready_i(ready_i), .hits_o(hits_o), .total_o(total_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // strobe generator: period 20, pulse at phase 0; comp_i follows comp_mode
  initial begin
    stb_i = 1'b0; stb_rdy_i = 1'b1; comp_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      p = (p + 1) % 20;
      stb_i = stb_en && p == 0;
      stb_rdy_i = stb_count >= rdy_until;
      if (stb_i) begin
        cur_masked = !stb_rdy_i;
        stb_count++;
      end
      comp_i = comp_mode == 1 ? 1'b1 : comp_mode == 2 ? (p >= 5 && p <= 7) :
               comp_mode == 3 ? cur_masked : 1'b0;
    end
  end

  typedef struct {
    int n, d, mode, skip, hits, total, lo, hi;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int k;
    logic seen, tot_valid;
    comp_mode = v.mode;
    rdy_until = stb_count + v.skip;
    n_samples_i = 16'(v.n); delay_i = 32'(v.d); start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; n_samples_i = 16'hBEEF; delay_i = 32'd1;
    check($sformatf("v%0d busy_at_S+1", idx), busy_o, 1);
    k = 1; seen = 1'b0; tot_valid = 1'b0;
    while (!valid_o && k < 2000) begin
      @(negedge clk); k++;
      if (!seen && total_o == 16'(v.total)) begin seen = 1'b1; tot_valid = valid_o; end
    end
    check($sformatf("v%0d valid_seen", idx), valid_o, 1);
    check($sformatf("v%0d hits", idx), hits_o, v.hits);
    check($sformatf("v%0d total", idx), total_o, v.total);
    check($sformatf("v%0d err", idx), err_o, 0);
    check($sformatf("v%0d valid_with_last_sample", idx), tot_valid, 1);
    check($sformatf("v%0d latency_in_range k=%0d", idx, k), k >= v.lo && k <= v.hi, 1);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check($sformatf("v%0d idle_after_hs", idx), {busy_o, valid_o}, 0);
  endtask

  initial begin
    int k;
    tbl[0] = '{4, 0, 1, 0, 4, 4, 1, 2000};
    tbl[1] = '{8, 5, 2, 0, 8, 8, 1, 2000};
    tbl[2] = '{8, 3, 2, 0, 0, 8, 1, 2000};
    tbl[3] = '{3, 0, 3, 2, 0, 3, 1, 2000};
    tbl[4] = '{3, 25, 1, 0, 3, 3, 105, 130};
    tbl[5] = '{5, 4, 0, 0, 0, 5, 1, 2000};
    tbl[6] = '{1, 0, 2, 0, 0, 1, 1, 2000};
    tbl[7] = '{2, 7, 2, 0, 2, 2, 1, 2000};
    tbl[8] = '{2, 8, 2, 0, 0, 2, 1, 2000};
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy_o, valid_o, err_o, hits_o, total_o}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {busy_o, valid_o}, 0);

    // ignored start during run, held result, back-to-back n=0 run
    comp_mode = 1; n_samples_i = 16'd4; delay_i = 32'd0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    k = 0;
    while (total_o != 16'd1 && k < 200) begin @(negedge clk); k++; end
    check("first_sample_reached", total_o, 1);
    n_samples_i = 16'd1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    k = 0;
    while (!valid_o && k < 200) begin @(negedge clk); k++; end
    check("ign_start_total", total_o, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold_%0d", i), {valid_o, busy_o, err_o, hits_o, total_o}, {3'b110, 16'd4, 16'd4});
    end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check("hs_idle", {busy_o, valid_o}, 0);
    n_samples_i = 16'd0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("n0_valid_at_S+1", {valid_o, busy_o, err_o, hits_o, total_o}, {3'b110, 32'd0});
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check("n0_idle", {busy_o, valid_o}, 0);

    // strobe stops after 3 of 10 samples -> timeout with partial result
    comp_mode = 1; n_samples_i = 16'd10; delay_i = 32'd0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    k = 0;
    while (total_o != 16'd3 && k < 300) begin @(negedge clk); k++; end
    stb_en = 1'b0;
    check("tmo_three_samples", total_o, 3);
    k = 0;
    while (!valid_o && k < 300) begin @(negedge clk); k++; end
    check("tmo_valid", valid_o, 1);
    check("tmo_err", err_o, 1);
    check("tmo_total", total_o, 3);
    check("tmo_hits", hits_o, 3);
    check($sformatf("tmo_cycles k=%0d", k), k >= 95 && k <= 105, 1);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    stb_en = 1'b1;
    check("tmo_idle", {busy_o, valid_o}, 0);

    // reset while in DELAY
    comp_mode = 1; n_samples_i = 16'd4; delay_i = 32'd10; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    k = 0;
    while (!stb_i && k < 100) begin @(negedge clk); k++; end
    @(negedge clk);
    check("pre_reset_busy", busy_o, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", {busy_o, valid_o, err_o, hits_o, total_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) run_vec(i, tbl[i]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
